// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: RV32 opcodes, control bundle
// layout and the alu_op / imm_sel / wb_sel encodings.
// Optional feature macro: DECODE_M_EXT_EN (RV32M multiply/divide decode).
package decode_stage_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // Immediate format; IMM_Z yields a zero immediate (R-type, unknown opcodes).
  typedef enum logic [2:0] {
    IMM_Z = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    imm_sel_e   imm_sel;
    logic [1:0] wb_sel;
    logic       is_jal;
    logic       is_jalr;
    logic       is_lui;
    logic       is_auipc;
    logic       is_alu_reg;
    logic       is_alu_imm;
    logic       is_load;
    logic       is_store;
    logic       is_system;
    logic       is_muldiv;
  } dec_ctrl_t;

  // Everything the buffer stores per entry apart from the PC.
  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    dec_ctrl_t   ctrl;
    logic        illegal;
  } dec_out_t;

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32I decoder: instruction word to register fields,
// sign-extended immediate, control bundle and illegal flag.
// Optional feature macro: DECODE_M_EXT_EN (funct7=0000001 on OP is legal MUL/DIV).
module decode_comb
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_out_t    dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  dec_ctrl_t   ctrl;
  logic        illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Opcode decode into the control bundle, then illegal-entry squashing.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:   begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.imm_sel = IMM_U; ctrl.is_lui   = 1'b1; end
      OPC_AUIPC: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.imm_sel = IMM_U; ctrl.is_auipc = 1'b1; end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1;
        ctrl.imm_sel = IMM_J; ctrl.wb_sel = WB_PC4; ctrl.is_jal = 1'b1;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1;
        ctrl.imm_sel = IMM_I; ctrl.wb_sel = WB_PC4; ctrl.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_OP_BRANCH; ctrl.imm_sel = IMM_B; end
      OPC_LOAD: begin
        ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; ctrl.alu_src = 1'b1;
        ctrl.imm_sel = IMM_I; ctrl.wb_sel = WB_LOAD; ctrl.is_load = 1'b1;
      end
      OPC_STORE: begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.imm_sel = IMM_S; ctrl.is_store = 1'b1; end
      OPC_OP_IMM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.imm_sel    = IMM_I;
        ctrl.is_alu_imm = 1'b1;
        ctrl.alu_op     = (funct3 == 3'b000) ? ALU_OP_ADD : ALU_OP_FUNCT;
        // Shift-immediates reuse imm[11:5] as a funct7 qualifier.
        if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
      end
      OPC_OP: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALU_OP_FUNCT;
        ctrl.is_alu_reg = 1'b1;
        if (funct7 == 7'b0000001) begin
`ifdef DECODE_M_EXT_EN
          ctrl.is_muldiv = 1'b1;
`else
          illegal = 1'b1;
`endif
        end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          illegal = 1'b1;
        end
      end
      OPC_MISC_MEM: begin ctrl.alu_src = 1'b1; ctrl.imm_sel = IMM_I; end
      OPC_SYSTEM:   begin ctrl.alu_src = 1'b1; ctrl.imm_sel = IMM_I; ctrl.is_system = 1'b1; end
      default:      illegal = 1'b1;
    endcase
    // An illegal entry must never cause an architectural side effect.
    if (illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
    end
  end

  // Immediate assembly for the selected RV32I format.
  always_comb begin
    case (ctrl.imm_sel)
      IMM_I:   imm = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm = {instr_i[31:12], 12'h000};
      IMM_J:   imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

  assign dec_o = '{rd: instr_i[11:7], rs1: instr_i[19:15], rs2: instr_i[24:20],
                   imm: imm, ctrl: ctrl, illegal: illegal};

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes each accepted instruction at the input and queues the
// result in a DEPTH-entry circular buffer feeding execute.
// Optional feature macro: DECODE_M_EXT_EN (RV32M decode, see decode_comb).
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [31:0]            out_imm,
  output dec_ctrl_t              out_ctrl,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dec_out_t         dec_in;
  dec_out_t         buf_q [DEPTH];
  logic [PC_W-1:0]  pc_q  [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic             push, pop;

  decode_comb u_decode_comb (
    .instr_i (in_instr),
    .dec_o   (dec_in)
  );

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = ready_q && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign out_count = count_q;

  // Pointer and occupancy next-state; flush wins over push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state; ready_q holds in_ready low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= 1'b1;
    end
  end

  // Payload storage written at the tail on every accepted transfer.
  always_ff @(posedge clk) begin
    // NOTE: payload memory is deliberately not reset; validity comes solely from count_q.
    if (push) begin
      buf_q[tail_q] <= dec_in;
      pc_q[tail_q]  <= in_pc;
    end
  end

  // Head-entry outputs, forced to zero whenever the buffer is empty.
  always_comb begin
    out_pc      = '0;
    out_rd      = '0;
    out_rs1     = '0;
    out_rs2     = '0;
    out_imm     = '0;
    out_ctrl    = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_pc      = pc_q[head_q];
      out_rd      = buf_q[head_q].rd;
      out_rs1     = buf_q[head_q].rs1;
      out_rs2     = buf_q[head_q].rs2;
      out_imm     = buf_q[head_q].imm;
      out_ctrl    = buf_q[head_q].ctrl;
      out_illegal = buf_q[head_q].illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based reference model and an independent RV32 decode function.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int PC_W  = 32;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [PC_W-1:0]        in_pc;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_W-1:0]        out_pc;
  logic [4:0]             out_rd, out_rs1, out_rs2;
  logic [31:0]            out_imm;
  dec_ctrl_t              out_ctrl;
  logic                   out_illegal;
  logic [$clog2(DEPTH):0] out_count;

  decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_ctrl(out_ctrl),
    .out_illegal(out_illegal), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    dec_ctrl_t   ctrl;
    logic        illegal;
  } exp_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  // Reference decode written straight from the RV32I/M rules.
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    logic [6:0] f7;
    logic [2:0] f3;
    e     = '0;
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    f7    = ins[31:25];
    f3    = ins[14:12];
    case (ins[6:0])
      7'h37, 7'h17: begin
        e.ctrl.reg_write = 1; e.ctrl.alu_src = 1; e.ctrl.imm_sel = IMM_U;
        e.ctrl.is_lui = (ins[6:0] == 7'h37); e.ctrl.is_auipc = (ins[6:0] == 7'h17);
        e.imm = ins & 32'hFFFF_F000;
      end
      7'h6F: begin
        e.ctrl.reg_write = 1; e.ctrl.jump = 1; e.ctrl.alu_src = 1; e.ctrl.imm_sel = IMM_J;
        e.ctrl.wb_sel = 2'd2; e.ctrl.is_jal = 1;
        e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h67: begin
        e.ctrl.reg_write = 1; e.ctrl.jump = 1; e.ctrl.alu_src = 1; e.ctrl.imm_sel = IMM_I;
        e.ctrl.wb_sel = 2'd2; e.ctrl.is_jalr = 1;
        e.imm = 32'($signed(ins[31:20]));
      end
      7'h63: begin
        e.ctrl.branch = 1; e.ctrl.alu_op = 2'b01; e.ctrl.imm_sel = IMM_B;
        e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'h03: begin
        e.ctrl.reg_write = 1; e.ctrl.mem_read = 1; e.ctrl.alu_src = 1; e.ctrl.imm_sel = IMM_I;
        e.ctrl.wb_sel = 2'd1; e.ctrl.is_load = 1;
        e.imm = 32'($signed(ins[31:20]));
      end
      7'h23: begin
        e.ctrl.mem_write = 1; e.ctrl.alu_src = 1; e.ctrl.imm_sel = IMM_S; e.ctrl.is_store = 1;
        e.imm = 32'($signed({ins[31:25], ins[11:7]}));
      end
      7'h13: begin
        e.ctrl.reg_write = 1; e.ctrl.alu_src = 1; e.ctrl.imm_sel = IMM_I; e.ctrl.is_alu_imm = 1;
        e.ctrl.alu_op = (f3 == 3'd0) ? 2'b00 : 2'b10;
        e.imm = 32'($signed(ins[31:20]));
        if (f3 == 3'd1) e.illegal = (f7 != 7'h00);
        if (f3 == 3'd5) e.illegal = !(f7 == 7'h00 || f7 == 7'h20);
      end
      7'h33: begin
        e.ctrl.reg_write = 1; e.ctrl.alu_op = 2'b10; e.ctrl.is_alu_reg = 1;
`ifdef DECODE_M_EXT_EN
        e.ctrl.is_muldiv = (f7 == 7'h01);
        e.illegal = !(f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01);
`else
        e.illegal = !(f7 == 7'h00 || f7 == 7'h20);
`endif
      end
      7'h0F: begin e.ctrl.alu_src = 1; e.ctrl.imm_sel = IMM_I; e.imm = 32'($signed(ins[31:20])); end
      7'h73: begin
        e.ctrl.alu_src = 1; e.ctrl.imm_sel = IMM_I; e.ctrl.is_system = 1;
        e.imm = 32'($signed(ins[31:20]));
      end
      default: e.illegal = 1;
    endcase
    if (e.illegal) begin
      e.ctrl.reg_write = 0; e.ctrl.mem_read = 0; e.ctrl.mem_write = 0;
      e.ctrl.branch = 0; e.ctrl.jump = 0;
    end
    return e;
  endfunction

  // Behavioural model: a bounded FIFO of {pc, instr}.
  entry_t mq[$];
  bit     m_ready;
  bit     m_push, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ready = 1'b0;
    end else begin
      if (flush) begin
        mq.delete();
      end else begin
        m_pop  = out_ready && (mq.size() != 0);
        m_push = in_valid && m_ready && (mq.size() < DEPTH);
        if (m_pop)  void'(mq.pop_front());
        if (m_push) mq.push_back('{pc: in_pc, instr: in_instr});
      end
      m_ready = 1'b1;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  exp_t ce;
  always @(negedge clk) begin
    check("valid", out_valid, mq.size() != 0);
    check("count", out_count, mq.size());
    check("in_ready", in_ready, m_ready && (mq.size() < DEPTH));
    if (mq.size() != 0) begin
      ce = ref_decode(mq[0].instr);
      check("pc", out_pc, mq[0].pc);
      check("regs", {out_rd, out_rs1, out_rs2}, {ce.rd, ce.rs1, ce.rs2});
      check("imm", out_imm, ce.imm);
      check("ctrl", out_ctrl, ce.ctrl);
      check("illegal", out_illegal, ce.illegal);
    end else begin
      check("idle_payload", {out_pc, out_imm}, 64'h0);
      check("idle_ctrl", {out_rd, out_rs1, out_rs2, out_ctrl, out_illegal}, '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 11))
      0, 1: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          2: r[31:25] = 7'h01;
          default: ;
        endcase
      end
      2, 3: begin
        r[6:0] = 7'h13;
        case ($urandom_range(0, 2))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          default: ;
        endcase
      end
      4: r[6:0] = 7'h03;
      5: r[6:0] = 7'h23;
      6: r[6:0] = 7'h63;
      7: r[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
      8: r[6:0] = ($urandom_range(0, 1) != 0) ? 7'h6F : 7'h67;
      9: r[6:0] = ($urandom_range(0, 1) != 0) ? 7'h73 : 7'h0F;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_count", out_count, 0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", in_ready, 1'b1);

    // addi x6,x1,127 into an empty buffer.
    in_valid = 1'b1; in_instr = 32'h07F0_8313; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    check("addi_valid", out_valid, 1'b1);
    check("addi_rd", out_rd, 5'd6);
    check("addi_rs1", out_rs1, 5'd1);
    check("addi_imm", out_imm, 32'h7F);
    check("addi_alu_op", out_ctrl.alu_op, 2'b00);
    check("addi_alu_src", out_ctrl.alu_src, 1'b1);
    check("addi_wb_sel", out_ctrl.wb_sel, 2'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Back-pressure: fill with lw x7,24(x3), then drain one per cycle.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_instr = 32'h0181_A383; in_pc = 32'h200 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    check("full_ready", in_ready, 1'b0);
    check("full_count", out_count, DEPTH);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("lw_pc", out_pc, 32'h200 + 32'(4 * i));
      check("lw_mem_read", out_ctrl.mem_read, 1'b1);
      check("lw_wb_sel", out_ctrl.wb_sel, 2'd1);
      check("lw_imm", out_imm, 32'd24);
      step();
      if (i == 0) check("ready_after_pop", in_ready, 1'b1);
    end
    out_ready = 1'b0;

    // Streaming: one in, one out per cycle.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_instr = 32'h0000_0013 | (32'(i) << 20); in_pc = 32'h400 + 32'(4 * i);
      step();
      check("stream_count", out_count, 1);
      check("stream_pc", out_pc, 32'h400 + 32'(4 * i));
    end
    in_valid = 1'b0; step(); out_ready = 1'b0;

    // Flush with a simultaneous push while two entries are held.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h500 + 32'(4 * i);
      step();
    end
    flush = 1'b1; in_pc = 32'hDEAD0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 1'b0);
    check("flush_count", out_count, 0);
    step();
    check("flush_no_ghost", out_pc, 32'h0);

    // mul x5,x1,x2.
    in_valid = 1'b1; in_instr = 32'h0220_82B3; in_pc = 32'h600;
    step();
    in_valid = 1'b0;
`ifdef DECODE_M_EXT_EN
    check("mul_muldiv", out_ctrl.is_muldiv, 1'b1);
    check("mul_illegal", out_illegal, 1'b0);
    check("mul_reg_write", out_ctrl.reg_write, 1'b1);
`else
    check("mul_illegal", out_illegal, 1'b1);
    check("mul_reg_write", out_ctrl.reg_write, 1'b0);
    check("mul_muldiv", out_ctrl.is_muldiv, 1'b0);
`endif
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Reset in the middle of a cycle with two entries held.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h700 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ready", in_ready, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_instr = 32'h07F0_8313; in_pc = 32'h300;
    step();
    in_valid = 1'b0;
    check("postrst_pc", out_pc, 32'h300);
    check("postrst_count", out_count, 1);
    out_ready = 1'b1; step();

    // Randomized traffic checked every cycle by the compare process.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom();
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    check("drained", out_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
